// File: rtl/pifo_tree_scheduler_pkg.sv
// pifo_sched_pkg: shared types and width helpers for the PIFO tree scheduler.
package pifo_sched_pkg;
   typedef enum logic {OP_PUSH, OP_POP} op_e;
   localparam int MAX_TIW = 8;
   function automatic int tiw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cw(input int cap);
      return $clog2(cap + 1);
   endfunction
   typedef struct packed {
      logic               vld;
      logic [MAX_TIW-1:0] id;
   } tag_t;
endpackage

// File: rtl/pifo_tree_scheduler_arb.sv
// rr_arbiter: first eligible requester at or after the pointer, with next pointer.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_elig,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_next
);
   logic [PW-1:0] w_idx;
   logic          w_found;
   always_comb begin
      o_gnt   = '0;
      o_next  = i_ptr;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = PW'((int'(i_ptr) + i) % N);
         if (!w_found && i_elig[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_next       = PW'((int'(w_idx) + 1) % N);
            w_found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/pifo_tree_scheduler.sv
// pifo_tree_scheduler: round-robin sharing of one PIFO level port among NREQ trees,
// with per-tree occupancy tracking and pop-data return routing.
module pifo_tree_scheduler
   import pifo_sched_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int PTW     = 8,
   parameter  int CAP     = 16,
   parameter  int POP_LAT = 2,
   localparam int TIW     = tiw(NREQ),
   localparam int CW      = cw(CAP)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NREQ-1:0]     i_req_push,
   input  logic [NREQ-1:0]     i_req_pop,
   input  logic [NREQ*PTW-1:0] i_req_data,
   output logic [NREQ-1:0]     o_gnt,
   output logic                o_gnt_pop,
   output logic [NREQ-1:0]     o_rsp_valid,
   output logic [PTW-1:0]      o_rsp_data,
   output logic [NREQ*CW-1:0]  o_occ,
   output logic                o_push,
   output logic                o_pop,
   output logic [PTW-1:0]      o_push_data,
   output logic [TIW-1:0]      o_tree_id,
   input  logic [PTW-1:0]      i_pop_data,
   input  logic                i_task_fifo_full
);
   logic [CW-1:0]   r_occ [NREQ];
   logic [TIW-1:0]  r_ptr, r_tree_id, w_next, w_win;
   logic            r_push, r_pop, w_any;
   logic [PTW-1:0]  r_push_data;
   logic [NREQ-1:0] w_pop_ok, w_push_ok, w_gnt;
   op_e             w_op;
   tag_t            r_tag [POP_LAT];
   tag_t            w_tag_out;

   always_comb begin
      w_pop_ok  = '0;
      w_push_ok = '0;
      o_occ     = '0;
      for (int r = 0; r < NREQ; r++) begin
         w_pop_ok[r]         = i_req_pop[r] && r_occ[r] != '0;
         w_push_ok[r]        = i_req_push[r] && r_occ[r] != CW'(CAP) && !i_task_fifo_full;
         o_occ[r*CW +: CW]   = r_occ[r];
      end
   end

   rr_arbiter #(.N(NREQ), .PW(TIW)) u_arb (
      .i_elig (w_pop_ok | w_push_ok),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt),
      .o_next (w_next)
   );

   always_comb begin
      w_win = '0;
      for (int r = 0; r < NREQ; r++)
         if (w_gnt[r]) w_win = TIW'(r);
   end

   // pop wins over a simultaneous push on the same tree
   assign w_any     = |w_gnt;
   assign w_op      = |(w_gnt & w_pop_ok) ? OP_POP : OP_PUSH;
   assign o_gnt     = w_gnt;
   assign o_gnt_pop = w_any && w_op == OP_POP;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr       <= '0;
         r_push      <= 1'b0;
         r_pop       <= 1'b0;
         r_push_data <= '0;
         r_tree_id   <= '0;
         for (int r = 0; r < NREQ; r++) r_occ[r] <= '0;
         for (int i = 0; i < POP_LAT; i++) r_tag[i] <= '0;
      end else begin
         if (w_any) begin
            r_ptr        <= w_next;
            r_occ[w_win] <= (w_op == OP_POP) ? r_occ[w_win] - CW'(1) : r_occ[w_win] + CW'(1);
         end
         r_push      <= w_any && w_op == OP_PUSH;
         r_pop       <= w_any && w_op == OP_POP;
         r_push_data <= (w_any && w_op == OP_PUSH) ? i_req_data[w_win*PTW +: PTW] : '0;
         r_tree_id   <= w_any ? w_win : '0;
         r_tag[0]    <= '{vld: r_pop, id: MAX_TIW'(r_tree_id)};
         for (int i = 1; i < POP_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign o_push      = r_push;
   assign o_pop       = r_pop;
   assign o_push_data = r_push_data;
   assign o_tree_id   = r_tree_id;
   assign w_tag_out   = r_tag[POP_LAT-1];
   assign o_rsp_valid = w_tag_out.vld ? NREQ'(1) << w_tag_out.id[TIW-1:0] : '0;
   assign o_rsp_data  = w_tag_out.vld ? i_pop_data : '0;
endmodule

// File: tb/tb_pifo_tree_scheduler.sv
// tb_pifo_tree_scheduler: directed scenarios with command/response scoreboard queues.
module tb_pifo_tree_scheduler;
   localparam int NREQ = 4, PTW = 8, CAP = 16, POP_LAT = 2, CW = 5, TIW = 2;

   logic             clk = 1'b0, rst = 1'b1, full = 1'b0;
   logic [3:0]       req_push = '0, req_pop = '0;
   logic [7:0]       dat [4];
   logic [31:0]      req_data;
   logic [3:0]       o_gnt, o_rsp_valid;
   logic             o_gnt_pop, o_push, o_pop;
   logic [7:0]       o_rsp_data, o_push_data, pop_data;
   logic [19:0]      o_occ;
   logic [1:0]       o_tree_id;
   int               cyc = 0, n_cmp = 0, n_err = 0;
   logic             no_rsp = 1'b0;

   typedef struct {logic pop; logic [1:0] id; logic [7:0] data; logic rsp;} cmd_t;
   typedef struct {logic [3:0] vld; logic [7:0] data;} rsp_t;
   cmd_t cmd_q[$];
   rsp_t rsp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pd(input int c);
      return 8'(c * 3 + 7);
   endfunction

   assign req_data = {dat[3], dat[2], dat[1], dat[0]};
   assign pop_data = pd(cyc);

   pifo_tree_scheduler #(.NREQ(NREQ), .PTW(PTW), .CAP(CAP), .POP_LAT(POP_LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_push(req_push), .i_req_pop(req_pop),
      .i_req_data(req_data), .o_gnt(o_gnt), .o_gnt_pop(o_gnt_pop),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_occ(o_occ),
      .o_push(o_push), .o_pop(o_pop), .o_push_data(o_push_data), .o_tree_id(o_tree_id),
      .i_pop_data(pop_data), .i_task_fifo_full(full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [CW-1:0] occ(input int r);
      return o_occ[r*CW +: CW];
   endfunction

   always @(negedge clk) begin
      cmd_t e;
      rsp_t r;
      if (o_push || o_pop) begin
         if (cmd_q.size() == 0) chk("cmd_extra", 32'(o_tree_id), 32'hDEAD);
         else begin
            e = cmd_q.pop_front();
            chk("cmd_pop", 32'(o_pop), 32'(e.pop));
            chk("cmd_push", 32'(o_push), 32'(!e.pop));
            chk("cmd_id", 32'(o_tree_id), 32'(e.id));
            chk("cmd_data", 32'(o_push_data), 32'(e.data));
            if (e.pop && e.rsp) rsp_q.push_back('{4'(1) << e.id, pd(cyc + POP_LAT)});
         end
      end else chk("idle_cmd", 32'({o_tree_id, o_push_data}), 32'h0);
      if (o_rsp_valid != '0) begin
         if (rsp_q.size() == 0) chk("rsp_extra", 32'(o_rsp_valid), 32'h0);
         else begin
            r = rsp_q.pop_front();
            chk("rsp_vld", 32'(o_rsp_valid), 32'(r.vld));
            chk("rsp_data", 32'(o_rsp_data), 32'(r.data));
         end
      end else chk("rsp_idle", 32'(o_rsp_data), 32'h0);
   end

   task automatic drive(input logic [3:0] psh, input logic [3:0] pp, input logic [3:0] g, input string tag);
      logic [1:0] id;
      logic       p;
      id = '0;
      req_push = psh;
      req_pop  = pp;
      #1;
      chk({tag, "_gnt"}, 32'(o_gnt), 32'(g));
      if (g != '0) begin
         for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
         p = (pp & g) != '0;
         chk({tag, "_gpop"}, 32'(o_gnt_pop), 32'(p));
         cmd_q.push_back('{p, id, p ? 8'h0 : dat[id], !no_rsp});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_push = '0;
      req_pop  = '0;
      full     = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out", 32'({o_push, o_pop, o_tree_id, o_push_data, o_rsp_valid, o_rsp_data, o_gnt, o_gnt_pop}), 32'h0);
      chk("rst_occ", 32'(o_occ), 32'h0);
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      req_push = '0;
      req_pop  = '0;
      for (int i = 0; i < 20 && (cmd_q.size() + rsp_q.size()) != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_drain"}, 32'(cmd_q.size() + rsp_q.size()), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         dat[2] = 8'(i);
         drive(4'b0100, 4'b0000, 4'b0100, "t1_push");
      end
      chk("t1_occ2", 32'(occ(2)), 32'd3);
      drain("t1");

      do_reset();
      repeat (3) drive(4'b0000, 4'b0100, 4'b0000, "t2_empty");
      dat[2] = 8'h55;
      drive(4'b0100, 4'b0000, 4'b0100, "t2_push");
      drive(4'b0000, 4'b0100, 4'b0100, "t2_pop");
      drain("t2");
      chk("t2_occ2", 32'(occ(2)), 32'd0);

      do_reset();
      for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
      drive(4'hF, 4'h0, 4'b0001, "t3_rr0");
      drive(4'hF, 4'h0, 4'b0010, "t3_rr1");
      drive(4'hF, 4'h0, 4'b0100, "t3_rr2");
      drive(4'hF, 4'h0, 4'b1000, "t3_rr3");
      drive(4'hF, 4'h0, 4'b0001, "t3_rr4");
      chk("t3_occ", 32'(o_occ), 32'({5'd1, 5'd1, 5'd1, 5'd2}));
      drain("t3");

      do_reset();
      for (int i = 0; i < CAP; i++) begin
         dat[0] = 8'(i + 1);
         drive(4'b0001, 4'b0000, 4'b0001, "t4_fill");
      end
      chk("t4_occ_full", 32'(occ(0)), 32'd16);
      repeat (2) drive(4'b0001, 4'b0000, 4'b0000, "t4_cap");
      drive(4'b0001, 4'b0001, 4'b0001, "t4_pop");
      chk("t4_occ_pop", 32'(occ(0)), 32'd15);
      dat[0] = 8'hC3;
      drive(4'b0001, 4'b0000, 4'b0001, "t4_refill");
      chk("t4_occ_refill", 32'(occ(0)), 32'd16);
      drain("t4");

      do_reset();
      dat[3] = 8'h33;
      repeat (2) drive(4'b1000, 4'b0000, 4'b1000, "t5_fill");
      chk("t5_occ3", 32'(occ(3)), 32'd2);
      full = 1'b1;
      dat[1] = 8'h77;
      repeat (2) drive(4'b0010, 4'b1000, 4'b1000, "t5_pop");
      drive(4'b0010, 4'b1000, 4'b0000, "t5_blk");
      drive(4'b0010, 4'b0000, 4'b0000, "t5_blk2");
      full = 1'b0;
      drive(4'b0010, 4'b0000, 4'b0010, "t5_go");
      chk("t5_occ", 32'(o_occ), 32'({5'd0, 5'd0, 5'd1, 5'd0}));
      drain("t5");

      do_reset();
      dat[1] = 8'h21;
      repeat (2) drive(4'b0010, 4'b0000, 4'b0010, "t6_fill");
      no_rsp = 1'b1;
      repeat (2) drive(4'b0000, 4'b0010, 4'b0010, "t6_pop");
      do_reset();
      no_rsp = 1'b0;
      repeat (5) @(posedge clk);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
